// File: rtl/time2stamp_seq_pkg.sv
// Shared calendar constants, error codes and FSM state type for the
// calendar-to-epoch converter.
package time2stamp_seq_pkg;

  localparam int unsigned SEC_PER_MIN      = 32'd60;
  localparam int unsigned SEC_PER_HOUR     = 32'd3600;
  localparam int unsigned SEC_PER_DAY      = 32'd86400;
  localparam int unsigned SEC_PER_YEAR     = 32'd31536000;
  localparam int unsigned SEC_PER_LEAPYEAR = 32'd31622400;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_FIELD = 2'b01;
  localparam logic [1:0] ERR_UNDER = 2'b10;
  localparam logic [1:0] ERR_OVER  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_YEARS,
    ST_MONTHS,
    ST_FINAL,
    ST_DONE
  } state_e;

  function automatic logic is_leap(input logic [13:0] y);
    return ((y[1:0] == 2'b00) && ((y % 14'd100) != 14'd0)) || ((y % 14'd400) == 14'd0);
  endfunction

endpackage

// File: rtl/time2stamp_seq_cal_month_len.sv
// Days in a month for a given year (leap-aware February). Out-of-range
// months report 31; callers reject those months separately.
module time2stamp_seq_cal_month_len
  import time2stamp_seq_pkg::*;
(
  input  logic [13:0] year_i,
  input  logic [3:0]  month_i,
  output logic [4:0]  days_o
);

  always_comb begin
    days_o = 5'd31;
    case (month_i)
      4'd2:                    days_o = is_leap(year_i) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: days_o = 5'd30;
      default:                 days_o = 5'd31;
    endcase
  end

endmodule

// File: rtl/time2stamp_seq.sv
// Sequential calendar-to-epoch converter: validates a local date/time plus
// UTC offset, then walks years and months to build UTC seconds since epoch.
//
// state  | meaning
// IDLE   | ready for a request
// CHECK  | validate registered fields
// YEARS  | add one whole year per cycle
// MONTHS | add one whole month per cycle
// FINAL  | add day/time-of-day, remove offset, classify result
// DONE   | hold result until consumed
module time2stamp_seq
  import time2stamp_seq_pkg::*;
#(
  parameter int STAMP_W    = 64,
  parameter int EPOCH_YEAR = 1970,
  parameter int MAX_YEAR   = 9999,
  parameter bit TZ_EN      = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [13:0]        year,
  input  logic [3:0]         month,
  input  logic [4:0]         day,
  input  logic [4:0]         hour,
  input  logic [5:0]         minute,
  input  logic [5:0]         second,
  input  logic signed [10:0] tz_offset_min,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STAMP_W-1:0] time_stamp,
  output logic [1:0]         err
);

  localparam int AW = STAMP_W + 2;
  localparam logic [13:0] EPOCH_Y = 14'(EPOCH_YEAR);
  localparam logic [13:0] MAX_Y   = 14'(MAX_YEAR);
  localparam logic signed [AW-1:0] STAMP_MAX = $signed({2'b00, {STAMP_W{1'b1}}});
  localparam logic signed [AW-1:0] SIXTY     = AW'(SEC_PER_MIN);
  localparam logic signed [10:0] TZ_MIN = -11'sd720;
  localparam logic signed [10:0] TZ_MAX = 11'sd840;

  state_e state_q, state_d;
  logic [13:0] year_q, year_d;
  logic [3:0]  month_q, month_d;
  logic [4:0]  day_q, day_d, hour_q, hour_d;
  logic [5:0]  minute_q, minute_d, second_q, second_d;
  logic signed [10:0] tz_q, tz_d;
  logic [13:0] y_q, y_d;
  logic [3:0]  m_q, m_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic        ovf_q, ovf_d;
  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic [1:0]  err_q, err_d;

  logic [3:0]  ml_month;
  logic [4:0]  ml_days;
  logic        fields_bad;
  logic [31:0] tod;
  logic signed [AW-1:0] year_add, month_add, step_add, step_sum;
  logic signed [AW-1:0] tod_ext, tz_ext, tz_sec, final_sum;

  // One month-length table serves both day validation and month accumulation.
  assign ml_month = (state_q == ST_CHECK) ? month_q : m_q;

  time2stamp_seq_cal_month_len u_month_len (
    .year_i  (year_q),
    .month_i (ml_month),
    .days_o  (ml_days)
  );

  assign fields_bad = (month_q == 4'd0) || (month_q > 4'd12) ||
                      (day_q == 5'd0) || (day_q > ml_days) ||
                      (hour_q > 5'd23) || (minute_q > 6'd59) || (second_q > 6'd59) ||
                      (year_q < EPOCH_Y) || (year_q > MAX_Y) ||
                      (tz_q < TZ_MIN) || (tz_q > TZ_MAX);

  assign year_add  = is_leap(y_q) ? AW'(SEC_PER_LEAPYEAR) : AW'(SEC_PER_YEAR);
  assign month_add = AW'(32'(ml_days) * SEC_PER_DAY);
  assign step_add  = (state_q == ST_YEARS) ? year_add : month_add;
  assign step_sum  = acc_q + step_add;

  assign tod = (32'(day_q) - 32'd1) * SEC_PER_DAY + 32'(hour_q) * SEC_PER_HOUR +
               32'(minute_q) * SEC_PER_MIN + 32'(second_q);
  assign tod_ext   = AW'(tod);
  assign tz_ext    = {{(AW-11){tz_q[10]}}, tz_q};
  assign tz_sec    = tz_ext * SIXTY;
  assign final_sum = acc_q + tod_ext - tz_sec;

  always_comb begin
    state_d  = state_q;
    year_d   = year_q;
    month_d  = month_q;
    day_d    = day_q;
    hour_d   = hour_q;
    minute_d = minute_q;
    second_d = second_q;
    tz_d     = tz_q;
    y_d      = y_q;
    m_d      = m_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    stamp_d  = stamp_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          year_d   = year;
          month_d  = month;
          day_d    = day;
          hour_d   = hour;
          minute_d = minute;
          second_d = second;
          tz_d     = TZ_EN ? tz_offset_min : 11'sd0;
          state_d  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (fields_bad) begin
          stamp_d = '0;
          err_d   = ERR_FIELD;
          state_d = ST_DONE;
        end else begin
          acc_d = '0;
          ovf_d = 1'b0;
          y_d   = EPOCH_Y;
          m_d   = 4'd1;
          if (year_q != EPOCH_Y)     state_d = ST_YEARS;
          else if (month_q != 4'd1)  state_d = ST_MONTHS;
          else                       state_d = ST_FINAL;
        end
      end
      ST_YEARS, ST_MONTHS: begin
        // Overflow freezes the accumulator but the walk still runs to the end.
        if (!ovf_q) begin
          if (step_sum > STAMP_MAX) ovf_d = 1'b1;
          else                      acc_d = step_sum;
        end
        if (state_q == ST_YEARS) begin
          y_d = y_q + 14'd1;
          if (y_q == year_q - 14'd1) state_d = (month_q != 4'd1) ? ST_MONTHS : ST_FINAL;
        end else begin
          m_d = m_q + 4'd1;
          if (m_q == month_q - 4'd1) state_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        if (ovf_q || (final_sum > STAMP_MAX)) begin
          stamp_d = '1;
          err_d   = ERR_OVER;
        end else if (final_sum[AW-1]) begin
          stamp_d = '0;
          err_d   = ERR_UNDER;
        end else begin
          stamp_d = final_sum[STAMP_W-1:0];
          err_d   = ERR_OK;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      year_q   <= '0;
      month_q  <= '0;
      day_q    <= '0;
      hour_q   <= '0;
      minute_q <= '0;
      second_q <= '0;
      tz_q     <= '0;
      y_q      <= '0;
      m_q      <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      stamp_q  <= '0;
      err_q    <= ERR_OK;
    end else begin
      state_q  <= state_d;
      year_q   <= year_d;
      month_q  <= month_d;
      day_q    <= day_d;
      hour_q   <= hour_d;
      minute_q <= minute_d;
      second_q <= second_d;
      tz_q     <= tz_d;
      y_q      <= y_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      stamp_q  <= stamp_d;
      err_q    <= err_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign time_stamp = stamp_q;
  assign err        = err_q;

endmodule

// File: tb/tb_time2stamp_seq.sv
// Bench for time2stamp_seq: a 64-bit and a 32-bit instance share stimulus;
// results are checked against a closed-form calendar model.
module tb_time2stamp_seq;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready;
  logic [13:0] year;
  logic [3:0]  month;
  logic [4:0]  day, hour;
  logic [5:0]  minute, second;
  logic signed [10:0] tz;
  logic in_ready64, out_valid64, in_ready32, out_valid32;
  logic [63:0] ts64;
  logic [31:0] ts32;
  logic [1:0]  err64, err32;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  time2stamp_seq #(.STAMP_W(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
    .year(year), .month(month), .day(day), .hour(hour), .minute(minute),
    .second(second), .tz_offset_min(tz), .out_valid(out_valid64),
    .out_ready(out_ready), .time_stamp(ts64), .err(err64)
  );

  time2stamp_seq #(.STAMP_W(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .year(year), .month(month), .day(day), .hour(hour), .minute(minute),
    .second(second), .tz_offset_min(tz), .out_valid(out_valid32),
    .out_ready(out_ready), .time_stamp(ts32), .err(err32)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint leaps_before(input longint y);
    return (y - 1) / 4 - (y - 1) / 100 + (y - 1) / 400;
  endfunction

  // Closed-form reference: whole days via leap counting, then seconds.
  function automatic void model(input int y, input int mo, input int d, input int h,
                                input int mi, input int s, input int tzm, input int w,
                                output logic [63:0] st, output logic [1:0] e, output int lat);
    int ml[12];
    bit leap;
    bit ok;
    longint days, ms, fin, lim;
    ml = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    if (leap) ml[1] = 29;
    ok = (mo >= 1) && (mo <= 12) && (y >= 1970) && (y <= 9999) &&
         (h <= 23) && (mi <= 59) && (s <= 59) && (tzm >= -720) && (tzm <= 840);
    if (ok) ok = (d >= 1) && (d <= ml[mo-1]);
    if (!ok) begin
      st = 64'd0; e = 2'b01; lat = 2;
      return;
    end
    days = 365 * longint'(y - 1970) + leaps_before(y) - leaps_before(1970);
    for (int m = 0; m < mo - 1; m++) days += ml[m];
    ms  = days * 86400;
    fin = ms + longint'(d - 1) * 86400 + h * 3600 + mi * 60 + s - longint'(tzm) * 60;
    lim = (w >= 63) ? 64'sh7fff_ffff_ffff_ffff : ((64'sd1 <<< w) - 1);
    lat = 3 + (y - 1970) + (mo - 1);
    if (ms > lim || fin > lim) begin
      st = (w >= 64) ? 64'hffff_ffff_ffff_ffff : 64'(lim); e = 2'b11;
    end else if (fin < 0) begin
      st = 64'd0; e = 2'b10;
    end else begin
      st = 64'(fin); e = 2'b00;
    end
  endfunction

  task automatic run_req(input int y, input int mo, input int d, input int h, input int mi,
                         input int s, input int tzm,
                         input logic [63:0] x64, input logic [1:0] xe64,
                         input logic [63:0] x32, input logic [1:0] xe32,
                         input int lat, input int hold, input string tag);
    int k;
    check_val($sformatf("%s in_ready", tag), 64'(in_ready64), 64'd1);
    year = 14'(y); month = 4'(mo); day = 5'(d); hour = 5'(h);
    minute = 6'(mi); second = 6'(s); tz = 11'(tzm);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    k = 0;
    @(negedge clk);
    while (!out_valid64 && k < 20000) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    check_val($sformatf("%s latency", tag), 64'(k + 1), 64'(lat));
    check_val($sformatf("%s valid32", tag), 64'(out_valid32), 64'd1);
    check_val($sformatf("%s stamp64", tag), ts64, x64);
    check_val($sformatf("%s err64", tag), 64'(err64), 64'(xe64));
    check_val($sformatf("%s stamp32", tag), 64'(ts32), x32);
    check_val($sformatf("%s err32", tag), 64'(err32), 64'(xe32));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      year = 14'($urandom_range(1970, 2100)); month = 4'($urandom_range(1, 12));
      @(posedge clk);
      @(negedge clk);
      check_val($sformatf("%s hold stamp", tag), ts64, x64);
      check_val($sformatf("%s hold err", tag), 64'(err64), 64'(xe64));
      check_val($sformatf("%s hold valid", tag), 64'(out_valid64), 64'd1);
      check_val($sformatf("%s hold in_ready", tag), 64'(in_ready64), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_val($sformatf("%s drop valid", tag), 64'(out_valid64), 64'd0);
    check_val($sformatf("%s ready64", tag), 64'(in_ready64), 64'd1);
    check_val($sformatf("%s ready32", tag), 64'(in_ready32), 64'd1);
  endtask

  task automatic model_req(input int y, input int mo, input int d, input int h, input int mi,
                           input int s, input int tzm, input string tag);
    logic [63:0] s64, s32;
    logic [1:0]  e64, e32;
    int l64, l32;
    model(y, mo, d, h, mi, s, tzm, 64, s64, e64, l64);
    model(y, mo, d, h, mi, s, tzm, 32, s32, e32, l32);
    run_req(y, mo, d, h, mi, s, tzm, s64, e64, s32, e32, l64, 0, tag);
  endtask

  function automatic int pick(input int lo, input int hi, input int bad_hi);
    return ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, bad_hi)) : int'($urandom_range(lo, hi));
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    year = '0; month = '0; day = '0; hour = '0; minute = '0; second = '0; tz = '0;
    #1;
    check_val("rst in_ready", 64'(in_ready64), 64'd1);
    check_val("rst out_valid", 64'(out_valid64), 64'd0);
    check_val("rst stamp", ts64, 64'd0);
    check_val("rst err", 64'(err64), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_req(1970, 1, 1, 0, 0, 0, 0, 64'd0, 2'b00, 64'd0, 2'b00, 3, 0, "epoch");
    run_req(2000, 3, 1, 0, 0, 0, 0, 64'd951868800, 2'b00, 64'd951868800, 2'b00, 35, 0, "y2000");
    run_req(2024, 2, 29, 12, 34, 56, 480, 64'd1709181296, 2'b00, 64'd1709181296, 2'b00, 58, 5, "leap_bp");
    run_req(2023, 2, 29, 0, 0, 0, 0, 64'd0, 2'b01, 64'd0, 2'b01, 2, 0, "feb29");
    run_req(2023, 13, 1, 0, 0, 0, 0, 64'd0, 2'b01, 64'd0, 2'b01, 2, 0, "mon13");
    run_req(2100, 2, 29, 0, 0, 0, 0, 64'd0, 2'b01, 64'd0, 2'b01, 2, 0, "y2100");
    run_req(1969, 12, 31, 23, 59, 59, 0, 64'd0, 2'b01, 64'd0, 2'b01, 2, 0, "pre_epoch");
    run_req(1970, 1, 1, 0, 0, 0, 841, 64'd0, 2'b01, 64'd0, 2'b01, 2, 0, "tz_hi");
    run_req(1970, 1, 1, 0, 0, 0, -721, 64'd0, 2'b01, 64'd0, 2'b01, 2, 0, "tz_lo");
    run_req(1970, 1, 1, 0, 0, 0, -720, 64'd43200, 2'b00, 64'd43200, 2'b00, 3, 0, "tz_min");
    run_req(1970, 1, 2, 0, 0, 0, 840, 64'd36000, 2'b00, 64'd36000, 2'b00, 3, 0, "tz_max");
    run_req(1970, 1, 1, 0, 30, 0, 60, 64'd0, 2'b10, 64'd0, 2'b10, 3, 0, "under");
    run_req(2106, 2, 7, 6, 28, 15, 0, 64'd4294967295, 2'b00, 64'hffff_ffff, 2'b00, 140, 0, "max32");
    run_req(2106, 2, 7, 6, 28, 16, 0, 64'd4294967296, 2'b00, 64'hffff_ffff, 2'b11, 140, 0, "ovf32");

    // Reset in the middle of the year walk.
    year = 14'd2050; month = 4'd6; day = 5'd15; hour = 5'd0; minute = 6'd0; second = 6'd0; tz = '0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("midrst out_valid", 64'(out_valid64), 64'd0);
    check_val("midrst in_ready", 64'(in_ready64), 64'd1);
    check_val("midrst stamp", ts64, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_req(2000, 3, 1, 0, 0, 0, 0, 64'd951868800, 2'b00, 64'd951868800, 2'b00, 35, 0, "after_rst");

    model_req(9999, 12, 31, 23, 59, 59, -720, "maxyear");

    for (int n = 0; n < 30; n++) begin
      model_req(int'($urandom_range(1965, 2200)), pick(1, 12, 15), pick(1, 28, 31),
                pick(0, 23, 31), pick(0, 59, 63), pick(0, 59, 63),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2047)) - 1024
                                            : int'($urandom_range(0, 1560)) - 720,
                $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
